// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the execution-unit controller: funct codes, result-mux
// encodings, FSM states and the single-cycle funct decoder.
package alu_ctrl_pkg;

  localparam logic [5:0] FunctAnd   = 6'b100100;
  localparam logic [5:0] FunctOr    = 6'b100101;
  localparam logic [5:0] FunctAdd   = 6'b100000;
  localparam logic [5:0] FunctSub   = 6'b100010;
  localparam logic [5:0] FunctSlt   = 6'b101010;
  localparam logic [5:0] FunctSrl   = 6'b000010;
  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMflo  = 6'b010010;

  typedef enum logic [1:0] {
    SelAlu   = 2'b00,
    SelShift = 2'b01,
    SelHi    = 2'b10,
    SelLo    = 2'b11
  } out_sel_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StWb   = 2'b10
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       multi;
    logic [5:0] alu_op;
    logic       inv;
    out_sel_e   out_sel;
  } decode_t;

  // MFHI/MFLO do not use the ALU; they park it on ADD so the slices stay quiet.
  function automatic decode_t decode_funct(input logic [5:0] funct);
    decode_t d;
    d = '{legal: 1'b1, multi: 1'b0, alu_op: FunctAdd, inv: 1'b0, out_sel: SelAlu};
    case (funct)
      FunctAnd, FunctOr, FunctAdd: d.alu_op = funct;
      FunctSub, FunctSlt: begin
        d.alu_op = funct;
        d.inv    = 1'b1;
      end
      FunctSrl:   d.out_sel = SelShift;
      FunctMfhi:  d.out_sel = SelHi;
      FunctMflo:  d.out_sel = SelLo;
      FunctMultu: d.multi   = 1'b1;
      default:    d.legal   = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Request/response bundle between the issue stage and the ALU controller.
interface alu_ctrl_if;
  logic       start;
  logic [5:0] funct;
  logic [5:0] alu_op;
  logic       inv;
  logic [1:0] out_sel;
  logic       mul_run;
  logic [5:0] mul_step;
  logic       hilo_we;
  logic       busy;
  logic       done;
  logic       illegal;

  modport master (
    output start, funct,
    input  alu_op, inv, out_sel, mul_run, mul_step, hilo_we, busy, done, illegal
  );

  modport slave (
    input  start, funct,
    output alu_op, inv, out_sel, mul_run, mul_step, hilo_we, busy, done, illegal
  );
endinterface

// File: rtl/alu_ctrl_step_counter.sv
// 6-bit multiply iteration counter; clear takes priority over enable.
module alu_ctrl_step_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 6'd1;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU controller: decodes R-type funct into ALU controls and sequences the
// multi-cycle MULTU with a step counter and a HI/LO write-back strobe.
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input logic     clk,
  input logic     rst,
  alu_ctrl_if.slave bus
);

  localparam logic [5:0] LastStep = 6'(MUL_CYCLES - 1);

  state_e     state_q;
  logic [5:0] alu_op_q;
  logic       inv_q;
  out_sel_e   out_sel_q;
  logic       mul_run_q;
  logic       hilo_we_q;
  logic       busy_q;
  logic       done_q;
  logic       illegal_q;

  logic [5:0] step;
  decode_t    dec;
  logic       accept;
  logic       step_clr;
  logic       step_en;

  assign dec      = decode_funct(bus.funct);
  assign accept   = (state_q == StIdle) && bus.start;
  assign step_clr = accept && dec.legal && dec.multi;
  assign step_en  = (state_q == StMul) && (step != LastStep);

  alu_ctrl_step_counter u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (step_clr),
    .en    (step_en),
    .count (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      alu_op_q  <= '0;
      inv_q     <= 1'b0;
      out_sel_q <= SelAlu;
      mul_run_q <= 1'b0;
      hilo_we_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      hilo_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!dec.legal) begin
              // Decoded controls hold so the datapath is not disturbed.
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
            end else begin
              alu_op_q  <= dec.alu_op;
              inv_q     <= dec.inv;
              out_sel_q <= dec.out_sel;
              if (dec.multi) begin
                mul_run_q <= 1'b1;
                busy_q    <= 1'b1;
                state_q   <= StMul;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
        end
        StMul: begin
          if (step == LastStep) begin
            mul_run_q <= 1'b0;
            hilo_we_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= StWb;
          end
        end
        StWb: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.alu_op   = alu_op_q;
  assign bus.inv      = inv_q;
  assign bus.out_sel  = out_sel_q;
  assign bus.mul_run  = mul_run_q;
  assign bus.mul_step = step;
  assign bus.hilo_we  = hilo_we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed-vector bench for alu_ctrl: a cycle-indexed behavioural model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_alu_ctrl;

  localparam int MulCycles = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_if bus_if ();

  alu_ctrl #(
    .MUL_CYCLES (MulCycles)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: multiply progress is derived from the edge index of acceptance.
  int         edge_no  = 0;
  int         mul_t0   = 0;
  bit         in_mul   = 1'b0;
  bit         model_ok = 1'b0;
  bit         alu_known = 1'b1;
  logic [5:0] e_alu_op = '0;
  logic       e_inv = 1'b0, e_run = 1'b0, e_hilo = 1'b0, e_busy = 1'b0;
  logic       e_done = 1'b0, e_illegal = 1'b0;
  logic [1:0] e_sel = '0;
  logic [5:0] e_step = '0;

  always @(posedge clk) begin
    bit prev_busy;
    int k;
    edge_no++;
    prev_busy = e_busy;
    if (rst) begin
      model_ok = 1'b1;
      in_mul = 1'b0; alu_known = 1'b1;
      e_alu_op = '0; e_inv = 0; e_sel = '0; e_run = 0; e_step = '0;
      e_hilo = 0; e_busy = 0; e_done = 0; e_illegal = 0;
    end else begin
      e_done = 0; e_illegal = 0; e_hilo = 0;
      if (in_mul) begin
        k = edge_no - mul_t0;
        if (k < MulCycles) begin
          e_run = 1; e_step = 6'(k); e_busy = 1;
        end else if (k == MulCycles) begin
          e_run = 0; e_hilo = 1; e_done = 1; e_busy = 1;
        end else begin
          e_busy = 0; in_mul = 1'b0;
        end
      end
      if (!prev_busy && bus_if.start) begin
        e_done = 1;
        case (bus_if.funct)
          6'b100100, 6'b100101, 6'b100000: begin
            e_alu_op = bus_if.funct; e_inv = 0; e_sel = 2'b00; alu_known = 1;
          end
          6'b100010, 6'b101010: begin
            e_alu_op = bus_if.funct; e_inv = 1; e_sel = 2'b00; alu_known = 1;
          end
          6'b000010: begin e_alu_op = 6'b100000; e_inv = 0; e_sel = 2'b01; alu_known = 1; end
          6'b010000: begin e_inv = 0; e_sel = 2'b10; alu_known = 0; end
          6'b010010: begin e_inv = 0; e_sel = 2'b11; alu_known = 0; end
          6'b011001: begin
            e_done = 0; e_alu_op = 6'b100000; e_inv = 0; e_sel = 2'b00; alu_known = 1;
            in_mul = 1'b1; mul_t0 = edge_no; e_run = 1; e_step = '0; e_busy = 1;
          end
          default: e_illegal = 1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      if (alu_known) check("model alu_op", 32'(bus_if.alu_op), 32'(e_alu_op));
      check("model inv",      32'(bus_if.inv),      32'(e_inv));
      check("model out_sel",  32'(bus_if.out_sel),  32'(e_sel));
      check("model mul_run",  32'(bus_if.mul_run),  32'(e_run));
      check("model mul_step", 32'(bus_if.mul_step), 32'(e_step));
      check("model hilo_we",  32'(bus_if.hilo_we),  32'(e_hilo));
      check("model busy",     32'(bus_if.busy),     32'(e_busy));
      check("model done",     32'(bus_if.done),     32'(e_done));
      check("model illegal",  32'(bus_if.illegal),  32'(e_illegal));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int run_cnt, busy_cnt, hilo_at, hilo_cnt;
    bus_if.start = 1'b0;
    bus_if.funct = '0;
    tick(); tick();
    check("reset alu_op", 32'(bus_if.alu_op), 32'h0);
    check("reset busy", 32'(bus_if.busy), 32'h0);
    check("reset mul_step", 32'(bus_if.mul_step), 32'h0);
    rst = 1'b0;
    tick();

    // SUB
    bus_if.start = 1'b1; bus_if.funct = 6'b100010;
    tick();
    bus_if.start = 1'b0;
    check("sub alu_op", 32'(bus_if.alu_op), 32'h22);
    check("sub inv", 32'(bus_if.inv), 32'h1);
    check("sub out_sel", 32'(bus_if.out_sel), 32'h0);
    check("sub done", 32'(bus_if.done), 32'h1);
    check("sub busy", 32'(bus_if.busy), 32'h0);
    tick();
    check("sub done drop", 32'(bus_if.done), 32'h0);

    // SLT then OR back-to-back
    bus_if.start = 1'b1; bus_if.funct = 6'b101010;
    tick();
    check("slt done", 32'(bus_if.done), 32'h1);
    check("slt inv", 32'(bus_if.inv), 32'h1);
    bus_if.funct = 6'b100101;
    tick();
    bus_if.start = 1'b0;
    check("or done", 32'(bus_if.done), 32'h1);
    check("or inv", 32'(bus_if.inv), 32'h0);
    check("or alu_op", 32'(bus_if.alu_op), 32'h25);

    // Illegal code holds decoded controls from OR
    bus_if.start = 1'b1; bus_if.funct = 6'b111111;
    tick();
    bus_if.start = 1'b0;
    check("ill done", 32'(bus_if.done), 32'h1);
    check("ill illegal", 32'(bus_if.illegal), 32'h1);
    check("ill alu_op held", 32'(bus_if.alu_op), 32'h25);
    check("ill inv held", 32'(bus_if.inv), 32'h0);
    tick();
    check("ill illegal drop", 32'(bus_if.illegal), 32'h0);

    // SLT then illegal: inv=1 must hold
    bus_if.start = 1'b1; bus_if.funct = 6'b101010;
    tick();
    bus_if.funct = 6'b111111;
    tick();
    bus_if.start = 1'b0;
    check("ill2 inv held", 32'(bus_if.inv), 32'h1);
    check("ill2 alu_op held", 32'(bus_if.alu_op), 32'h2a);

    // SRL and MFLO
    bus_if.start = 1'b1; bus_if.funct = 6'b000010;
    tick();
    check("srl out_sel", 32'(bus_if.out_sel), 32'h1);
    check("srl alu_op", 32'(bus_if.alu_op), 32'h20);
    bus_if.funct = 6'b010010;
    tick();
    bus_if.start = 1'b0;
    check("mflo out_sel", 32'(bus_if.out_sel), 32'h3);
    tick();

    // MULTU full sequence
    bus_if.start = 1'b1; bus_if.funct = 6'b011001;
    tick();
    bus_if.start = 1'b0;
    run_cnt = 0; busy_cnt = 0; hilo_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.mul_run) begin
        run_cnt++;
        check("mul step index", 32'(bus_if.mul_step), 32'(i));
      end
      if (bus_if.busy) busy_cnt++;
      if (bus_if.hilo_we) begin
        hilo_at = i;
        check("wb done", 32'(bus_if.done), 32'h1);
      end
      tick();
    end
    check("mul_run cycles", 32'(run_cnt), 32'd32);
    check("busy cycles", 32'(busy_cnt), 32'd33);
    check("hilo_we cycle", 32'(hilo_at), 32'd32);

    // MFHI held during a multiply
    bus_if.start = 1'b1; bus_if.funct = 6'b011001;
    tick();
    bus_if.funct = 6'b010000;
    for (int i = 0; i < 33; i++) tick();
    check("mfhi wait busy", 32'(bus_if.busy), 32'h0);
    check("mfhi wait done", 32'(bus_if.done), 32'h0);
    check("mfhi wait out_sel", 32'(bus_if.out_sel), 32'h0);
    tick();
    bus_if.start = 1'b0;
    check("mfhi out_sel", 32'(bus_if.out_sel), 32'h2);
    check("mfhi done", 32'(bus_if.done), 32'h1);
    tick();

    // Reset at mul_step 10
    bus_if.start = 1'b1; bus_if.funct = 6'b011001;
    tick();
    bus_if.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre-rst step", 32'(bus_if.mul_step), 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(bus_if.busy), 32'h0);
    check("abort mul_run", 32'(bus_if.mul_run), 32'h0);
    check("abort mul_step", 32'(bus_if.mul_step), 32'h0);
    check("abort alu_op", 32'(bus_if.alu_op), 32'h0);
    hilo_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.hilo_we) hilo_cnt++;
      tick();
    end
    check("abort hilo_we pulses", 32'(hilo_cnt), 32'd0);

    // Reset wins over start
    rst = 1'b1; bus_if.start = 1'b1; bus_if.funct = 6'b100010;
    tick();
    rst = 1'b0; bus_if.start = 1'b0;
    check("rst+start done", 32'(bus_if.done), 32'h0);
    check("rst+start inv", 32'(bus_if.inv), 32'h0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Execution-unit controller directly upstream of the bit-slice ALU. Decodes the R-type `funct` field into the ALU operation code and invert/carry-in control, and selects the result source. It also sequences the multi-cycle unsigned multiply (MULTU) with an internal step counter. The HI/LO write strobe and handshake flags it produces drive the multiplier, HI/LO register and result mux in the same execution unit.

## Interface
- `MUL_CYCLES`, 32, number of multiply iteration cycles; legal range 2..63.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  request: `funct` is valid this cycle.
- `funct`  in  6  R-type function code.
- `alu_op`  out  6  operation code broadcast to every ALU slice.
- `inv`  out  1  invert B and carry-in of slice 0 (SUB, SLT).
- `out_sel`  out  2  result mux select: 00 ALU, 01 shifter, 10 HI, 11 LO.
- `mul_run`  out  1  multiplier iterate enable.
- `mul_step`  out  6  current multiply iteration index.
- `hilo_we`  out  1  one-cycle HI/LO write strobe.
- `busy`  out  1  controller occupied; `start` is ignored while high.
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  qualifies `done`: the funct code was unsupported.

## Operation
- Supported funct codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010: `out_sel`=00, `alu_op`=funct.
  - SRL 000010: `out_sel`=01, `alu_op`=ADD.
  - MFHI 010000: `out_sel`=10.
  - MFLO 010010: `out_sel`=11.
  - MULTU 011001: multi-cycle, described below.
- `inv`=1 only for SUB and SLT; 0 for every other code.
- States: IDLE, MUL, WB.
- IDLE, `start`=1, single-cycle code: register `alu_op`, `inv`, `out_sel`; pulse `done`; remain in IDLE.
- IDLE, `start`=1, MULTU:
  - Set `alu_op`=ADD, `inv`=0, `out_sel`=00.
  - Go to MUL with `mul_step`=0 and `mul_run`=1.
- MUL: `mul_step` increments once per cycle. When `mul_step`=`MUL_CYCLES`-1, go to WB.
- WB: `mul_run`=0, `hilo_we`=1, `done`=1 for exactly one cycle, then go to IDLE.
- Unsupported code on `start`: pulse `done` and `illegal` together. `alu_op`, `inv` and `out_sel` hold their previous values.
- `start` in MUL or WB is ignored: no queueing, no error indication.
- `mul_step` holds its last value outside MUL and is cleared on MULTU entry.

## Timing
- Reset values: `alu_op`=000000, `inv`=0, `out_sel`=00, `mul_run`=0, `mul_step`=0, `hilo_we`=0, `busy`=0, `done`=0, `illegal`=0. State = IDLE.
- All outputs are registered.
- Single-cycle op with `start` sampled at edge N:
  - Decoded outputs are valid from N.
  - `done` is high only in cycle N..N+1.
  - `busy` stays 0.
- MULTU with `start` sampled at edge N:
  - `busy` and `mul_run` are high from N.
  - `mul_step` shows 0..`MUL_CYCLES`-1 on successive cycles.
  - WB is entered at edge N+`MUL_CYCLES`; `hilo_we`, `done` and `busy` are high that cycle.
  - `busy` falls at edge N+`MUL_CYCLES`+1.
- Back-to-back: a new `start` is accepted in the first cycle `busy`=0.
- Reset mid-multiply: immediate return to IDLE, all outputs at reset values, no `hilo_we`.
- `rst` and `start` in the same cycle: reset wins.

## Structure
- Shared package holds:
  - funct constants: AND, OR, ADD, SUB, SLT, SRL, MULTU, MFHI, MFLO;
  - `out_sel` encodings;
  - state encoding for IDLE/MUL/WB.
- Optional sub-module `step_counter`: 6-bit synchronous counter with clear and enable. The decode logic stays inline.

## Test plan
- Reset, then `start` with funct 100010 -> next cycle `alu_op`=100010, `inv`=1, `out_sel`=00, `done`=1 for one cycle, `busy`=0.
- `start` with 101010, then 100101 in the following cycle -> two consecutive `done` pulses. `inv` is 1 for the first and 0 for the second.
- `start` with 011001 (`MUL_CYCLES`=32):
  - `mul_run` is high for 32 cycles with `mul_step` 0..31.
  - Then `hilo_we`=`done`=1 in the 33rd cycle.
  - `busy` is high for 33 cycles total.
- `start` with 010000 held high during a multiply -> ignored until `busy`=0, then accepted: `out_sel`=10, `done`=1.
- `rst` asserted at `mul_step`=10 -> the next cycle shows all reset values and `hilo_we` never pulses.
- `start` with funct 111111 -> `done`=`illegal`=1 for one cycle; `alu_op`, `inv` and `out_sel` are unchanged.
